// File: rtl/sfot_ram_loader.sv
// sfot_ram_loader: parses a framed byte stream (sync, start addr, length, payload, checksum)
// into program-memory writes and holds the 65C02 in reset until a load completes cleanly.
module sfot_ram_loader #(
  parameter int         MEM_WIDTH     = 8,
  parameter int         MEM_ADDR_BITS = 14,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [MEM_WIDTH-1:0]     s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     abort,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]     mem_wdata,
  output logic                     cpu_hold,
  output logic                     load_done,
  output logic                     load_err
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR
  } state_t;

  localparam logic [16:0] MEM_SIZE = 17'd1 << MEM_ADDR_BITS;

  state_t                   state;
  logic [15:0]              start_addr;
  logic [7:0]               len_hi;
  logic [15:0]              remaining;
  logic [MEM_ADDR_BITS-1:0] wr_addr;
  logic [7:0]               csum;

  logic [15:0] frame_len;
  logic [16:0] frame_end;
  logic        range_bad;
  logic        in_frame;
  logic [7:0]  csum_next;

  assign s_ready   = 1'b1;
  assign frame_len = {len_hi, s_data};
  // 17-bit sum so a frame ending exactly at the top of memory is still accepted
  assign frame_end = {1'b0, start_addr} + {1'b0, frame_len};
  assign range_bad = ({1'b0, start_addr} >= MEM_SIZE) || (frame_end > MEM_SIZE);
  assign in_frame  = state inside {ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, CSUM};
  assign csum_next = csum + s_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      start_addr <= '0;
      len_hi     <= '0;
      remaining  <= '0;
      wr_addr    <= '0;
      csum       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (abort && in_frame) begin
        state    <= ERROR;
        load_err <= 1'b1;
        cpu_hold <= 1'b1;
      end else if (s_valid) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (s_data == SYNC_BYTE) begin
              state     <= ADDR_HI;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              cpu_hold  <= 1'b1;
              csum      <= '0;
            end
          end
          ADDR_HI: begin
            start_addr[15:8] <= s_data;
            state            <= ADDR_LO;
          end
          ADDR_LO: begin
            start_addr[7:0] <= s_data;
            state           <= LEN_HI;
          end
          LEN_HI: begin
            len_hi <= s_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            if (range_bad) begin
              state    <= ERROR;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end else if (frame_len == 16'd0) begin
              state <= CSUM;
            end else begin
              state     <= DATA;
              remaining <= frame_len;
              wr_addr   <= start_addr[MEM_ADDR_BITS-1:0];
            end
          end
          DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= s_data;
            wr_addr   <= wr_addr + 1'b1;
            remaining <= remaining - 16'd1;
            csum      <= csum_next;
            if (remaining == 16'd1) state <= CSUM;
          end
          CSUM: begin
            if (csum_next == 8'd0) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfot_ram_loader.sv
// tb_sfot_ram_loader: randomized self-checking bench; a frame-level reference model predicts
// the per-byte writes, final flags and resulting memory image of sfot_ram_loader.
`timescale 1ns/1ps
module tb_sfot_ram_loader;

  localparam int AB       = 14;
  localparam int MEM_SIZE = 1 << AB;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          abort;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  logic [7:0] model_mem [MEM_SIZE];
  logic [7:0] obs_mem   [MEM_SIZE];

  always #5 clk = ~clk;

  sfot_ram_loader dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .abort     (abort),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // One clock; outputs are sampled on the falling edge and any write is captured into obs_mem
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (mem_we === 1'b1) begin
      obs_mem[mem_addr] = mem_wdata;
      wr_count++;
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s idle mem_we actual=%0b required=0", name, mem_we);
      end
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit exp_we, input int exp_addr,
                            input string name);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
    if (exp_we) model_mem[exp_addr] = b;
    checks++;
    if (mem_we !== exp_we) begin
      failures++;
      $display("[TB] FAIL %s mem_we actual=%0b required=%0b", name, mem_we, exp_we);
    end else if (exp_we) begin
      checks++;
      if (mem_addr !== AB'(exp_addr) || mem_wdata !== b) begin
        failures++;
        $display("[TB] FAIL %s write actual=%h:%h required=%h:%h",
                 name, mem_addr, mem_wdata, AB'(exp_addr), b);
      end
    end
  endtask

  // Frame-level model: locate the sync, decode header, range-check, sum payload + checksum
  task automatic run_frame(input bq_t f, input int gap_max, input string name,
                           output bit exp_done, output bit exp_err);
    bit we_q[$];
    int addr_q[$];
    int s = -1;
    foreach (f[i]) begin
      we_q.push_back(1'b0);
      addr_q.push_back(0);
      if (s < 0 && f[i] == 8'hA5) s = i;
    end
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (s >= 0 && f.size() >= s + 5) begin
      int st = {f[s+1], f[s+2]};
      int ln = {f[s+3], f[s+4]};
      if (st >= MEM_SIZE || st + ln > MEM_SIZE) begin
        exp_err = 1'b1;
      end else if (f.size() > s + 5 + ln) begin
        int sum = 0;
        for (int k = 0; k < ln; k++) begin
          we_q[s+5+k]   = 1'b1;
          addr_q[s+5+k] = st + k;
          sum += f[s+5+k];
        end
        sum += f[s+5+ln];
        exp_done = (sum % 256) == 0;
        exp_err  = !exp_done;
      end
    end
    foreach (f[i]) begin
      int gap = (gap_max > 0) ? $urandom_range(gap_max, 1) : 0;
      if (gap > 0) idle_cycles(gap, name);
      drive_byte(f[i], we_q[i], addr_q[i], $sformatf("%s b%0d", name, i));
    end
  endtask

  function automatic bq_t build_frame(input int st, input int ln, input bit good_csum);
    bq_t f;
    int sum = 0;
    logic [7:0] c;
    f.push_back(8'hA5);
    f.push_back(st[15:8]);
    f.push_back(st[7:0]);
    f.push_back(ln[15:8]);
    f.push_back(ln[7:0]);
    for (int k = 0; k < ln; k++) begin
      logic [7:0] b = 8'($urandom);
      f.push_back(b);
      sum += b;
    end
    c = 8'(256 - (sum % 256));
    if (!good_csum) c = c + 8'($urandom_range(255, 1));
    f.push_back(c);
    return f;
  endfunction

  task automatic test_reset();
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    abort   = 1'b0;
    tick();
    tick();
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset s_ready actual=%0b required=1", s_ready); end
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset mem_we actual=%0b required=0", mem_we); end
    checks++;
    if (mem_addr !== '0) begin failures++; $display("[TB] FAIL reset mem_addr actual=%h required=0", mem_addr); end
    checks++;
    if (mem_wdata !== 8'h00) begin failures++; $display("[TB] FAIL reset mem_wdata actual=%h required=00", mem_wdata); end
    checks++;
    if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL reset cpu_hold actual=%0b required=1", cpu_hold); end
    checks++;
    if (load_done !== 1'b0) begin failures++; $display("[TB] FAIL reset load_done actual=%0b required=0", load_done); end
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL reset load_err actual=%0b required=0", load_err); end
    resetn = 1'b1;
    idle_cycles(3, "post_reset");
    checks++;
    if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL idle cpu_hold actual=%0b required=1", cpu_hold); end
  endtask

  task automatic test_good_frame();
    bq_t f = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    bit d, e;
    run_frame(f, 0, "good", d, e);
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL good flags done/err/hold actual=%b required=100", {load_done, load_err, cpu_hold});
    end
  endtask

  task automatic test_bad_csum();
    bq_t f = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
    bit d, e;
    int w0 = wr_count;
    run_frame(f, 0, "badcsum", d, e);
    checks++;
    if (wr_count - w0 !== 3) begin failures++; $display("[TB] FAIL badcsum writes actual=%0d required=3", wr_count - w0); end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL badcsum flags done/err/hold actual=%b required=011", {load_done, load_err, cpu_hold});
    end
  endtask

  task automatic test_range();
    bq_t f1 = {8'hA5, 8'h3F, 8'hFE, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    bq_t f2 = {8'hA5, 8'h3F, 8'hFD, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    bit d, e;
    int w0 = wr_count;
    run_frame(f1, 0, "range_over", d, e);
    checks++;
    if (wr_count - w0 !== 0) begin failures++; $display("[TB] FAIL range_over writes actual=%0d required=0", wr_count - w0); end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL range_over flags actual=%b required=011", {load_done, load_err, cpu_hold});
    end
    run_frame(f2, 0, "range_top", d, e);
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL range_top flags actual=%b required=100", {load_done, load_err, cpu_hold});
    end
  endtask

  task automatic test_zero_len();
    bq_t f1 = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    bq_t f2 = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    bit d, e;
    int w0 = wr_count;
    run_frame(f1, 0, "zero_ok", d, e);
    checks++;
    if (wr_count - w0 !== 0 || {load_done, load_err, cpu_hold} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL zero_ok writes/flags actual=%0d/%b required=0/100", wr_count - w0, {load_done, load_err, cpu_hold});
    end
    run_frame(f2, 0, "zero_bad", d, e);
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL zero_bad flags actual=%b required=011", {load_done, load_err, cpu_hold});
    end
  endtask

  task automatic test_back_to_back();
    bq_t f = build_frame($urandom_range(MEM_SIZE - 16, 0), $urandom_range(12, 4), 1'b1);
    bit d, e;
    int bad;
    f.push_front(8'h12);
    f.push_front(8'hFF);
    f.push_front(8'h00);
    for (int pass = 0; pass < 2; pass++) begin
      run_frame(f, pass == 0 ? 0 : 5, pass == 0 ? "b2b" : "gaps", d, e);
      checks++;
      if ({load_done, load_err, cpu_hold} !== {d, e, !d}) begin
        failures++;
        $display("[TB] FAIL b2b pass%0d flags actual=%b required=%b", pass, {load_done, load_err, cpu_hold}, {d, e, !d});
      end
      bad = 0;
      for (int a = 0; a < MEM_SIZE; a++) if (obs_mem[a] !== model_mem[a]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("[TB] FAIL b2b pass%0d memory actual=%0d bad bytes required=0", pass, bad); end
    end
  endtask

  task automatic test_abort();
    bit d, e;
    int w0 = wr_count;
    drive_byte(8'hA5, 1'b0, 0, "abort hdr0");
    drive_byte(8'h00, 1'b0, 0, "abort hdr1");
    drive_byte(8'h20, 1'b0, 0, "abort hdr2");
    drive_byte(8'h00, 1'b0, 0, "abort hdr3");
    drive_byte(8'h03, 1'b0, 0, "abort hdr4");
    drive_byte(8'h11, 1'b1, 16'h0020, "abort p0");
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h22;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL abort write actual=%0b required=0", mem_we); end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b011 || wr_count - w0 !== 1) begin
      failures++;
      $display("[TB] FAIL abort flags/writes actual=%b/%0d required=011/1", {load_done, load_err, cpu_hold}, wr_count - w0);
    end
    drive_byte(8'h33, 1'b0, 0, "abort tail0");
    drive_byte(8'h9A, 1'b0, 0, "abort tail1");
    run_frame(build_frame(16'h0030, 3, 1'b1), 2, "after_abort", d, e);
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL after_abort flags actual=%b required=100", {load_done, load_err, cpu_hold});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL abort_in_done flags actual=%b required=100", {load_done, load_err, cpu_hold});
    end
  endtask

  task automatic test_reset_mid();
    drive_byte(8'hA5, 1'b0, 0, "rst hdr0");
    drive_byte(8'h01, 1'b0, 0, "rst hdr1");
    drive_byte(8'h00, 1'b0, 0, "rst hdr2");
    drive_byte(8'h00, 1'b0, 0, "rst hdr3");
    drive_byte(8'h04, 1'b0, 0, "rst hdr4");
    drive_byte(8'h11, 1'b1, 16'h0100, "rst p0");
    resetn  = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h22;
    tick();
    s_valid = 1'b0;
    resetn  = 1'b1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, {AB{1'b0}}, 8'h00}) begin
      failures++;
      $display("[TB] FAIL reset_mid write port actual=%0b:%h:%h required=0:0000:00", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({s_ready, load_done, load_err, cpu_hold} !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL reset_mid flags rdy/done/err/hold actual=%b required=1001", {s_ready, load_done, load_err, cpu_hold});
    end
    drive_byte(8'h33, 1'b0, 0, "rst idle");
    checks++;
    if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL reset_mid idle cpu_hold actual=%0b required=1", cpu_hold); end
  endtask

  task automatic test_random();
    bit d, e;
    int bad;
    for (int n = 0; n < 20; n++) begin
      bq_t f;
      int kind = $urandom_range(3, 0);
      int ln   = $urandom_range(10, 0);
      if (kind == 3) begin
        int st = ($urandom_range(1, 0) == 1) ? $urandom_range(65535, MEM_SIZE)
                                             : MEM_SIZE - ln + $urandom_range(ln + 1, 1);
        if (ln == 0) ln = 1;
        f = build_frame(st, ln, 1'b1);
        f = f[0:4];
      end else begin
        f = build_frame($urandom_range(MEM_SIZE - ln, 0), ln, kind != 2);
      end
      for (int g = $urandom_range(3, 0); g > 0; g--) begin
        logic [7:0] gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        f.push_front(gb);
      end
      run_frame(f, $urandom_range(2, 0), $sformatf("rnd%0d", n), d, e);
      checks++;
      if ({load_done, load_err, cpu_hold} !== {d, e, !d}) begin
        failures++;
        $display("[TB] FAIL rnd%0d flags actual=%b required=%b", n, {load_done, load_err, cpu_hold}, {d, e, !d});
      end
    end
    bad = 0;
    for (int a = 0; a < MEM_SIZE; a++) if (obs_mem[a] !== model_mem[a]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL rnd memory actual=%0d bad bytes required=0", bad); end
  endtask

  initial begin
    for (int a = 0; a < MEM_SIZE; a++) begin
      model_mem[a] = 8'h00;
      obs_mem[a]   = 8'h00;
    end
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_range();
    test_zero_len();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
